// File: rtl/except_ctrl_pkg.sv
// Shared CPU exception defines: code width, exception codes and MEM-stage flag bit positions.
package except_ctrl_pkg;

    localparam int EXC_W = 4;

    localparam logic [EXC_W-1:0] EXC_NONE  = 4'd0;
    localparam logic [EXC_W-1:0] EXC_INT   = 4'd1;
    localparam logic [EXC_W-1:0] EXC_ADEL  = 4'd2;
    localparam logic [EXC_W-1:0] EXC_ADES  = 4'd3;
    localparam logic [EXC_W-1:0] EXC_WRPC  = 4'd4;
    localparam logic [EXC_W-1:0] EXC_SYS   = 4'd5;
    localparam logic [EXC_W-1:0] EXC_BREAK = 4'd6;
    localparam logic [EXC_W-1:0] EXC_RI    = 4'd7;
    localparam logic [EXC_W-1:0] EXC_OV    = 4'd8;
    localparam logic [EXC_W-1:0] EXC_ERET  = 4'd9;

    localparam int FLG_FETCH = 0;
    localparam int FLG_RI    = 1;
    localparam int FLG_SYS   = 2;
    localparam int FLG_BREAK = 3;
    localparam int FLG_OV    = 4;
    localparam int FLG_LOAD  = 5;
    localparam int FLG_STORE = 6;
    localparam int FLG_ERET  = 7;

    // Interrupt request from CP0: IE set, EXL clear, any unmasked pending line.
    function automatic logic int_request(input logic [31:0] status, input logic [31:0] cause);
        return status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
    endfunction

endpackage

// File: rtl/except_ctrl_prio_enc.sv
// Fixed-priority exception encoder: pending interrupt first, then MEM-stage flags low bit to high.
module exc_prio_enc
    import except_ctrl_pkg::*;
(
    input  logic             int_pending,
    input  logic [7:0]       flags,
    output logic [EXC_W-1:0] code,
    output logic             fetch_fault
);

    always_comb begin
        code = EXC_NONE;
        if (int_pending)           code = EXC_INT;
        else if (flags[FLG_FETCH]) code = EXC_ADEL;
        else if (flags[FLG_RI])    code = EXC_RI;
        else if (flags[FLG_SYS])   code = EXC_SYS;
        else if (flags[FLG_BREAK]) code = EXC_BREAK;
        else if (flags[FLG_OV])    code = EXC_OV;
        else if (flags[FLG_LOAD])  code = EXC_ADEL;
        else if (flags[FLG_STORE]) code = EXC_ADES;
        else if (flags[FLG_ERET])  code = EXC_ERET;
    end

    // The bad address is the PC only when the winning cause is the fetch fault.
    assign fetch_fault = ~int_pending & flags[FLG_FETCH];

endmodule

// File: rtl/except_ctrl.sv
// Exception controller: picks the MEM-stage exception, pulses flush with CP0 context,
// then holds the front end until the hold time expires and fetch accepts the redirect.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter int FLUSH_HOLD = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_valid,
    input  logic [31:0]      mem_pc,
    input  logic             mem_in_delay_slot,
    input  logic [7:0]       mem_exc_flags,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      cp0_status,
    input  logic [31:0]      cp0_cause,
    input  logic             redirect_ready,
    output logic [EXC_W-1:0] except_type_cp0,
    output logic             delay_slot_cp0,
    output logic [31:0]      pc_mempt2,
    output logic [31:0]      mem_addr_ex,
    output logic             flush,
    output logic             stall_req
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_INIT = FLUSH_HOLD[3:0];

    state_t           state, state_nxt;
    logic             int_pending_q;
    logic [3:0]       hold_cnt;
    logic [EXC_W-1:0] sel_code;
    logic             fetch_fault;
    logic             take;
    logic [EXC_W-1:0] code_q;
    logic [31:0]      pc_q;
    logic [31:0]      badaddr_q;
    logic             ds_q;
    logic             unused_bits;

    assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) int_pending_q <= 1'b0;
        else         int_pending_q <= int_request(cp0_status, cp0_cause);
    end

    exc_prio_enc u_prio (
        .int_pending (int_pending_q),
        .flags       (mem_exc_flags),
        .code        (sel_code),
        .fetch_fault (fetch_fault)
    );

    assign take = mem_valid && (state == S_IDLE) && (sel_code != EXC_NONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        except_type_cp0 = EXC_NONE;
        flush           = 1'b0;
        stall_req       = 1'b0;
        delay_slot_cp0  = 1'b0;
        pc_mempt2       = 32'h0;
        mem_addr_ex     = 32'h0;
        case (state)
            S_IDLE: begin
                if (take) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                except_type_cp0 = code_q;
                flush           = 1'b1;
                stall_req       = 1'b1;
                delay_slot_cp0  = ds_q;
                pc_mempt2       = pc_q;
                mem_addr_ex     = badaddr_q;
                state_nxt       = S_WAIT;
            end
            S_WAIT: begin
                stall_req = 1'b1;
                if (hold_cnt == 4'd0 && redirect_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counting through FLUSH as well makes the number of WAIT cycles equal FLUSH_HOLD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                 hold_cnt <= 4'd0;
        else if (take)                               hold_cnt <= HOLD_INIT;
        else if (state != S_IDLE && hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            code_q    <= EXC_NONE;
            pc_q      <= 32'h0;
            badaddr_q <= 32'h0;
            ds_q      <= 1'b0;
        end else if (take) begin
            code_q    <= sel_code;
            pc_q      <= mem_pc;
            badaddr_q <= fetch_fault ? mem_pc : mem_addr;
            ds_q      <= mem_in_delay_slot;
        end
    end

endmodule

// File: tb/tb_except_ctrl.sv
// Bench for except_ctrl: flush pulses are checked against a queue of expected CP0 records.
module tb_except_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_in_delay_slot;
    logic [7:0]  mem_exc_flags;
    logic [31:0] mem_addr;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic        redirect_ready;
    logic [3:0]  except_type_cp0;
    logic        delay_slot_cp0;
    logic [31:0] pc_mempt2;
    logic [31:0] mem_addr_ex;
    logic        flush;
    logic        stall_req;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   n;

    always #5 clk = ~clk;

    except_ctrl #(.FLUSH_HOLD(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_valid         (mem_valid),
        .mem_pc            (mem_pc),
        .mem_in_delay_slot (mem_in_delay_slot),
        .mem_exc_flags     (mem_exc_flags),
        .mem_addr          (mem_addr),
        .cp0_status        (cp0_status),
        .cp0_cause         (cp0_cause),
        .redirect_ready    (redirect_ready),
        .except_type_cp0   (except_type_cp0),
        .delay_slot_cp0    (delay_slot_cp0),
        .pc_mempt2         (pc_mempt2),
        .mem_addr_ex       (mem_addr_ex),
        .flush             (flush),
        .stall_req         (stall_req)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one MEM-stage instruction for a single cycle and queue what CP0 should see.
    task automatic present(input logic [7:0] flags, input logic [31:0] pc, input logic [31:0] addr,
                           input logic ds, input logic [3:0] code, input logic [31:0] bad);
        exp_t e;
        mem_valid = 1'b1; mem_exc_flags = flags; mem_pc = pc; mem_addr = addr; mem_in_delay_slot = ds;
        e.code = code; e.pc = pc; e.ds = ds; e.addr = bad;
        sb.push_back(e);
        tick();
        mem_valid = 1'b0; mem_exc_flags = 8'h00;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (stall_req && cyc < 40) begin
            cyc++;
            tick();
        end
        if (cyc >= 40) chk("idle_timeout", 32'(cyc), 32'd0);
    endtask

    // Scoreboard side: every flush cycle must match the oldest queued record.
    always @(negedge clk) begin
        if (resetn && flush) begin
            if (sb.size() == 0) begin
                chk("spurious_flush", 32'(flush), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("code", 32'(except_type_cp0), 32'(e.code));
                chk("pc", pc_mempt2, e.pc);
                chk("ds", 32'(delay_slot_cp0), 32'(e.ds));
                chk("badaddr", mem_addr_ex, e.addr);
            end
        end
    end

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; mem_pc = 32'h0; mem_in_delay_slot = 1'b0;
        mem_exc_flags = 8'h00; mem_addr = 32'h0; cp0_status = 32'h0; cp0_cause = 32'h0;
        redirect_ready = 1'b1;
        #23;
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_code", 32'(except_type_cp0), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Overflow; redirect_ready held high from FLUSH -> three stall cycles.
        present(8'h10, 32'hBFC00100, 32'h00001234, 1'b0, 4'd8, 32'h00001234);
        chk("ov_flush_now", 32'(flush), 32'd1);
        wait_idle(n);
        chk("stall_cycles", 32'(n), 32'd3);

        // Fetch fault beats load fault; bad address is the PC.
        present(8'h21, 32'h80001000, 32'h000055AA, 1'b0, 4'd2, 32'h80001000);
        wait_idle(n);

        // Further priority patterns.
        present(8'hFE, 32'h80002000, 32'h0000A000, 1'b0, 4'd7, 32'h0000A000);
        wait_idle(n);
        present(8'hC0, 32'h80002004, 32'h0000B004, 1'b1, 4'd3, 32'h0000B004);
        wait_idle(n);
        present(8'h88, 32'h80002008, 32'h0000C008, 1'b0, 4'd6, 32'h0000C008);
        wait_idle(n);
        present(8'h80, 32'h8000200C, 32'h0000D00C, 1'b0, 4'd9, 32'h0000D00C);
        wait_idle(n);

        // Redirect not ready: stall persists until it rises.
        redirect_ready = 1'b0;
        present(8'h20, 32'h80003000, 32'h00000003, 1'b0, 4'd2, 32'h00000003);
        repeat (6) tick();
        chk("hold_no_ready", 32'(stall_req), 32'd1);
        redirect_ready = 1'b1;
        tick();
        chk("release_ready", 32'(stall_req), 32'd0);

        // Interrupt: pending the cycle after request, then taken with delay-slot context.
        cp0_status = 32'h00000401; cp0_cause = 32'h00000400;
        tick();
        chk("int_pending", 32'(dut.int_pending_q), 32'd1);
        present(8'h02, 32'h80004000, 32'h00000040, 1'b1, 4'd1, 32'h00000040);
        cp0_status = 32'h0; cp0_cause = 32'h0;
        wait_idle(n);

        // Second syscall presented during WAIT must wait until IDLE.
        present(8'h04, 32'h80005000, 32'h00000050, 1'b0, 4'd5, 32'h00000050);
        mem_valid = 1'b1; mem_exc_flags = 8'h04; mem_pc = 32'h80005004; mem_addr = 32'h00000054;
        wait_idle(n);
        chk("first_sys_stall", 32'(n), 32'd3);
        chk("one_pending", 32'(sb.size()), 32'd0);
        present(8'h04, 32'h80005004, 32'h00000054, 1'b0, 4'd5, 32'h00000054);
        wait_idle(n);

        // Reset during WAIT aborts the sequence.
        present(8'h10, 32'h80006000, 32'h00000060, 1'b0, 4'd8, 32'h00000060);
        tick();
        resetn = 1'b0;
        #1;
        chk("rst_wait_stall", 32'(stall_req), 32'd0);
        chk("rst_wait_flush", 32'(flush), 32'd0);
        tick();
        resetn = 1'b1;
        repeat (5) tick();
        chk("post_rst_stall", 32'(stall_req), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_HOLD, default 2, minimum WAIT-state cycles before a redirect is accepted (legal 1..15).
REQ-002 SHALL have port clk  in  1  system clock, all state on posedge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_valid  in  1  MEM-stage instruction valid.
REQ-005 SHALL have port mem_pc  in  32  MEM-stage PC.
REQ-006 SHALL have port mem_in_delay_slot  in  1  MEM instruction is in a delay slot.
REQ-007 SHALL have port mem_exc_flags  in  8  exception flags: bit0 fetch-addr, bit1 RI, bit2 syscall, bit3 break, bit4 overflow, bit5 load-addr, bit6 store-addr, bit7 eret.
REQ-008 SHALL have port mem_addr  in  32  MEM data address.
REQ-009 SHALL have ports cp0_status, cp0_cause  in  32 each  current CP0 Status and Cause.
REQ-010 SHALL have port redirect_ready  in  1  fetch has accepted the new PC.
REQ-011 SHALL have port except_type_cp0  out  EXC_W  exception code to CP0.
REQ-012 SHALL have ports delay_slot_cp0 (1), pc_mempt2 (32), mem_addr_ex (32)  out  exception context to CP0.
REQ-013 SHALL have port flush  out  1  pipeline flush pulse.
REQ-014 SHALL have port stall_req  out  1  hold pipeline front end.

Function
REQ-015 SHALL compute int_req = status[0] & ~status[1] & |(cause[15:8] & status[15:8]), registered into int_pending_q every cycle.
REQ-016 SHALL select one code per cycle with fixed priority: INT(int_pending_q) > fetch-addr > RI > syscall > break > overflow > load-addr > store-addr > eret > NONE.
REQ-017 SHALL treat selection as valid only when mem_valid=1 and state=IDLE.
REQ-018 SHALL use a 3-state FSM: IDLE, FLUSH, WAIT.
REQ-019 In IDLE with a valid non-NONE code, SHALL register code, mem_pc, mem_in_delay_slot and the bad address, and go to FLUSH next cycle.
REQ-020 SHALL set the bad address to mem_pc for fetch-addr, mem_addr for load/store-addr, otherwise mem_addr.
REQ-021 In FLUSH (exactly one cycle), SHALL drive except_type_cp0=registered code, flush=1, stall_req=1, then go to WAIT.
REQ-022 In FLUSH, SHALL drive delay_slot_cp0, pc_mempt2 and mem_addr_ex from registered context.
REQ-023 Outside FLUSH, SHALL drive except_type_cp0=NONE and flush=0.
REQ-024 In WAIT, SHALL drive stall_req=1 and decrement a 4-bit hold counter loaded with FLUSH_HOLD on FLUSH entry.
REQ-025 SHALL leave WAIT to IDLE only when counter=0 and redirect_ready=1; stall_req SHALL drop the same cycle the FSM reaches IDLE.
REQ-026 SHALL ignore redirect_ready in IDLE and FLUSH and while counter!=0.
REQ-027 SHALL ignore mem_valid and mem_exc_flags in FLUSH and WAIT; an interrupt arriving then SHALL remain in int_pending_q and be taken on the first valid IDLE cycle.
REQ-028 SHALL report only the highest-priority code when several flags are set simultaneously.
REQ-029 SHALL report INT with the MEM instruction's PC/delay-slot context (no instruction-specific code is reported).

Reset
REQ-030 On resetn=0, SHALL asynchronously force state=IDLE, int_pending_q=0, counter=0, all context registers=0, except_type_cp0=NONE, flush=0, stall_req=0.
REQ-031 Reset asserted mid-FLUSH or mid-WAIT SHALL abort the sequence with no further flush pulse after release.

Structure
REQ-032 SHALL take EXC_W=4 and codes NONE=0, INT=1, ADEL=2, ADES=3, WRPC=4, SYS=5, BREAK=6, RI=7, OV=8, ERET=9 from the shared CPU defines package; FSM state encodings stay local.
REQ-033 SHALL place priority selection in one combinational sub-module exc_prio_enc (flags + int_pending_q -> code).

Verification
REQ-034 Bench SHALL check: mem_valid=1, flags=0x10, pc=0xBFC00100 -> next cycle except_type=OV(8), flush=1, pc_mempt2=0xBFC00100.
REQ-035 Bench SHALL check: flags=0x21 (fetch+load) -> ADEL code from fetch, mem_addr_ex=mem_pc.
REQ-036 Bench SHALL check: status=0x00000401, cause IP2=1 -> int_pending_q next cycle, then INT(1) with delay_slot_cp0 mirroring mem_in_delay_slot=1.
REQ-037 Bench SHALL check: FLUSH_HOLD=2, redirect_ready held 1 from FLUSH -> stall_req high exactly 3 cycles (FLUSH+2 WAIT), IDLE on 4th.
REQ-038 Bench SHALL check: syscall accepted, second syscall presented in WAIT -> single flush pulse only; second taken after IDLE.
REQ-039 Bench SHALL check: resetn pulsed low during WAIT -> stall_req=0 immediately, no flush after release.
